// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART receive slice.
// Parity modes, FIFO entry layout, divider math and FSM states.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  localparam int unsigned E_DATA = 0;

  function automatic int unsigned e_perr(
    input int unsigned fw
  );
    return fw;
  endfunction

  function automatic int unsigned e_ferr(
    input int unsigned fw
  );
    return fw + 1;
  endfunction

  function automatic int unsigned e_brk(
    input int unsigned fw
  );
    return fw + 2;
  endfunction

  function automatic int unsigned calc_div(
    input int unsigned clk_hz,
    input int unsigned baud,
    input int unsigned os
  );
    int unsigned d;
    d = clk_hz / (baud * os);
    return (d < 1) ? 1 : d;
  endfunction

  function automatic int unsigned par_mode(
    input string p
  );
    if (p == "EVEN") return PAR_EVEN;
    if (p == "ODD")  return PAR_ODD;
    return PAR_NONE;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BRK_WAIT
  } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: received-frame stream with valid/ready handshake.
// master = receiver core, slave = consumer.
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int unsigned FRAME_WD = 8
);
  logic [FRAME_WD-1:0] rx_data;
  logic rx_perr;
  logic rx_ferr;
  logic rx_break;
  logic rx_valid;
  logic rx_ready;
  logic rx_overrun;

  modport master (
    output rx_data, rx_perr, rx_ferr,
    output rx_break, rx_valid, rx_overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_perr, rx_ferr,
    input  rx_break, rx_valid, rx_overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: small synchronous show-ahead FIFO.
// Head is read straight from storage; a full push is ignored.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rp];

  // storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp      <= wp + 1'b1;
      end
      if (do_pop) rp <= rp + 1'b1;
      if (do_push && !do_pop) cnt <= cnt + 1'b1;
      else if (!do_push && do_pop) cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver with majority vote,
// parity/stop/break status and a buffered valid/ready output.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCE = 50_000_000,
  parameter int unsigned BAUD_RATE     = 115200,
  parameter int unsigned OVERSAMPLE    = 16,
  parameter int unsigned FRAME_WD      = 8,
  parameter string       PARITY        = "NONE",
  parameter int unsigned STOP_BITS     = 1,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      uart_rx,
  uart_rx_if.master rx,
  output logic      busy
);
  localparam int unsigned DIV =
    calc_div(CLK_FREQUENCE, BAUD_RATE, OVERSAMPLE);
  localparam int unsigned PMODE = par_mode(PARITY);
  localparam bit PAR_EN  = (PMODE != PAR_NONE);
  localparam bit PAR_INV = (PMODE == PAR_ODD);
  localparam int unsigned EW = FRAME_WD + 3;
  localparam int unsigned M  = OVERSAMPLE / 2;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [DW-1:0] DLAST = DW'(DIV - 1);
  localparam logic [SW-1:0] SM0   = SW'(M - 1);
  localparam logic [SW-1:0] SM1   = SW'(M);
  localparam logic [SW-1:0] SM2   = SW'(M + 1);
  localparam logic [SW-1:0] SLAST = SW'(OVERSAMPLE - 1);
  localparam logic [3:0] BLAST = 4'(FRAME_WD);
  localparam logic SCLAST = 1'(STOP_BITS - 1);

  rx_state_e state_q, state_d;
  logic s1, s2, s3;
  logic start_det, tick, dec, bit_end, maj;
  logic [DW-1:0] div_q;
  logic [SW-1:0] s_cnt_q;
  logic v0, v1;
  logic [FRAME_WD-1:0] data_q, data_d;
  logic [3:0] bcnt_q, bcnt_d;
  logic par_q, par_d;
  logic ferr_q, ferr_d;
  logic scnt_q, scnt_d;
  logic push, brk, perr, is_brk;
  logic pop, full, empty, ovr_q;
  logic [EW-1:0] entry, head;

  // two-flop synchroniser plus edge register, idle high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= uart_rx;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign start_det = s3 & ~s2 & (state_q == S_IDLE);
  assign tick      = (div_q == DLAST);

  // oversample tick divider, realigned on start edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_q <= '0;
    else if (start_det || tick) div_q <= '0;
    else div_q <= div_q + 1'b1;
  end

  // sample position within a bit and the two early votes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_cnt_q <= '0;
      v0      <= 1'b1;
      v1      <= 1'b1;
    end else if (start_det) begin
      s_cnt_q <= '0;
    end else if (tick) begin
      s_cnt_q <= (s_cnt_q == SLAST) ? '0 : s_cnt_q + 1'b1;
      if (s_cnt_q == SM0) v0 <= s2;
      if (s_cnt_q == SM1) v1 <= s2;
    end
  end

  assign dec     = tick & (s_cnt_q == SM2);
  assign bit_end = tick & (s_cnt_q == SLAST);
  assign maj     = (v0 & v1) | (v0 & s2) | (v1 & s2);

  assign perr   = PAR_EN & (^data_q ^ par_q ^ PAR_INV);
  assign is_brk = ~scnt_q & (data_q == '0) & ~maj
                & (~PAR_EN | ~par_q);

  // frame state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      bcnt_q  <= '0;
      par_q   <= 1'b0;
      ferr_q  <= 1'b0;
      scnt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      bcnt_q  <= bcnt_d;
      par_q   <= par_d;
      ferr_q  <= ferr_d;
      scnt_q  <= scnt_d;
    end
  end

  // frame sequencing; entry pushed at last stop-bit decision
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    bcnt_d  = bcnt_q;
    par_d   = par_q;
    ferr_d  = ferr_q;
    scnt_d  = scnt_q;
    push    = 1'b0;
    brk     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_det) begin
          state_d = S_START;
          bcnt_d  = '0;
          par_d   = 1'b0;
          ferr_d  = 1'b0;
          scnt_d  = 1'b0;
        end
      end
      S_START: begin
        if (dec && maj) state_d = S_IDLE;
        else if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (dec) begin
          data_d = {maj, data_q[FRAME_WD-1:1]};
          bcnt_d = bcnt_q + 1'b1;
        end
        if (bit_end && bcnt_q == BLAST)
          state_d = PAR_EN ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (dec) par_d = maj;
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (dec) begin
          ferr_d = ferr_q | ~maj;
          if (is_brk) begin
            push    = 1'b1;
            brk     = 1'b1;
            state_d = S_BRK_WAIT;
          end else if (scnt_q == SCLAST) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            scnt_d = 1'b1;
          end
        end
      end
      S_BRK_WAIT: begin
        if (s2) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign entry = {brk, ferr_d, perr, data_q};
  assign pop   = rx.rx_valid & rx.rx_ready;

  uart_rx_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (entry),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // flag a frame dropped into a full, non-draining FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovr_q <= 1'b0;
    else ovr_q <= push & full & ~pop;
  end

  assign rx.rx_data    = head[E_DATA +: FRAME_WD];
  assign rx.rx_perr    = head[e_perr(FRAME_WD)];
  assign rx.rx_ferr    = head[e_ferr(FRAME_WD)];
  assign rx.rx_break   = head[e_brk(FRAME_WD)];
  assign rx.rx_valid   = ~empty;
  assign rx.rx_overrun = ovr_q;
  assign busy          = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed vectors for 8N1, 8E1, 8O1 and 8N2
// receivers at 32 clk/bit, plus latency/glitch/break/overrun runs.
module tb_uart_rx_core;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] line;
  logic [3:0] rdy;
  wire  [3:0] vld;
  wire  [3:0] ovr;
  wire  [3:0] busy;
  wire  [10:0] ent [4];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t_first = -1;
  int ovr_n [4];
  logic [10:0] got [4][$];

  always #5 clk = ~clk;

  uart_rx_if #(.FRAME_WD(8)) if0 ();
  uart_rx_if #(.FRAME_WD(8)) if1 ();
  uart_rx_if #(.FRAME_WD(8)) if2 ();
  uart_rx_if #(.FRAME_WD(8)) if3 ();

  uart_rx_core #(
    .CLK_FREQUENCE(3_200_000), .BAUD_RATE(100_000),
    .OVERSAMPLE(16), .FRAME_WD(8), .PARITY("NONE"),
    .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .uart_rx(line[0]),
    .rx(if0.master), .busy(busy[0])
  );

  uart_rx_core #(
    .CLK_FREQUENCE(3_200_000), .BAUD_RATE(100_000),
    .OVERSAMPLE(16), .FRAME_WD(8), .PARITY("EVEN"),
    .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .uart_rx(line[1]),
    .rx(if1.master), .busy(busy[1])
  );

  uart_rx_core #(
    .CLK_FREQUENCE(3_200_000), .BAUD_RATE(100_000),
    .OVERSAMPLE(16), .FRAME_WD(8), .PARITY("ODD"),
    .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .uart_rx(line[2]),
    .rx(if2.master), .busy(busy[2])
  );

  uart_rx_core #(
    .CLK_FREQUENCE(3_200_000), .BAUD_RATE(100_000),
    .OVERSAMPLE(16), .FRAME_WD(8), .PARITY("NONE"),
    .STOP_BITS(2), .FIFO_DEPTH(4)
  ) dut3 (
    .clk(clk), .rst_n(rst_n), .uart_rx(line[3]),
    .rx(if3.master), .busy(busy[3])
  );

  assign if0.rx_ready = rdy[0];
  assign if1.rx_ready = rdy[1];
  assign if2.rx_ready = rdy[2];
  assign if3.rx_ready = rdy[3];

  assign vld = {if3.rx_valid, if2.rx_valid,
                if1.rx_valid, if0.rx_valid};
  assign ovr = {if3.rx_overrun, if2.rx_overrun,
                if1.rx_overrun, if0.rx_overrun};

  assign ent[0] = {if0.rx_break, if0.rx_ferr,
                   if0.rx_perr, if0.rx_data};
  assign ent[1] = {if1.rx_break, if1.rx_ferr,
                   if1.rx_perr, if1.rx_data};
  assign ent[2] = {if2.rx_break, if2.rx_ferr,
                   if2.rx_perr, if2.rx_data};
  assign ent[3] = {if3.rx_break, if3.rx_ferr,
                   if3.rx_perr, if3.rx_data};

  always @(posedge clk) cyc <= cyc + 1;

  initial for (int k = 0; k < 4; k++) ovr_n[k] = 0;

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (vld[k] && rdy[k]) got[k].push_back(ent[k]);
      if (ovr[k]) ovr_n[k] = ovr_n[k] + 1;
    end
    if (vld[0] && t_first < 0) t_first = cyc;
  end

  typedef struct {
    int          k;
    logic [7:0]  d;
    logic        hp;
    logic        p;
    int          ns;
    logic [1:0]  st;
    logic [10:0] exp;
  } vec_t;

  vec_t tv [14];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bitt(input int k, input logic v);
    line[k] = v;
    idle(32);
  endtask

  task automatic send(input int k, input logic [7:0] d,
                      input logic hp, input logic p,
                      input int ns, input logic [1:0] st);
    bitt(k, 1'b0);
    for (int i = 0; i < 8; i++) bitt(k, d[i]);
    if (hp) bitt(k, p);
    for (int i = 0; i < ns; i++) bitt(k, st[i]);
    line[k] = 1'b1;
  endtask

  initial begin
    int k;
    int n0;
    int o0;
    int c0;
    int dl;

    tv[0]  = '{0, 8'hA5, 1'b0, 1'b0, 1, 2'b01, 11'h0A5};
    tv[1]  = '{0, 8'h00, 1'b0, 1'b0, 1, 2'b01, 11'h000};
    tv[2]  = '{0, 8'hFF, 1'b0, 1'b0, 1, 2'b01, 11'h0FF};
    tv[3]  = '{0, 8'h3C, 1'b0, 1'b0, 1, 2'b00, 11'h23C};
    tv[4]  = '{1, 8'h07, 1'b1, 1'b0, 1, 2'b01, 11'h107};
    tv[5]  = '{1, 8'h07, 1'b1, 1'b1, 1, 2'b01, 11'h007};
    tv[6]  = '{2, 8'h07, 1'b1, 1'b0, 1, 2'b01, 11'h007};
    tv[7]  = '{2, 8'h07, 1'b1, 1'b1, 1, 2'b01, 11'h107};
    tv[8]  = '{3, 8'h3C, 1'b0, 1'b0, 2, 2'b01, 11'h23C};
    tv[9]  = '{3, 8'h3C, 1'b0, 1'b0, 2, 2'b10, 11'h23C};
    tv[10] = '{3, 8'h5A, 1'b0, 1'b0, 2, 2'b11, 11'h05A};
    tv[11] = '{1, 8'h00, 1'b1, 1'b0, 1, 2'b01, 11'h000};
    tv[12] = '{1, 8'h80, 1'b1, 1'b0, 1, 2'b01, 11'h180};
    tv[13] = '{2, 8'h00, 1'b1, 1'b0, 1, 2'b00, 11'h700};

    rst_n = 1'b0;
    line  = 4'hF;
    rdy   = 4'hF;
    idle(3);
    rst_n = 1'b1;
    idle(4);

    chk("rst_valid", 32'(vld), 0);
    chk("rst_ovr", 32'(ovr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_head", 32'(ent[0]), 0);

    n0 = got[0].size();
    c0 = cyc;
    t_first = -1;
    send(0, 8'hA5, 1'b0, 1'b0, 1, 2'b01);
    idle(64);
    dl = t_first - c0;
    chk("lat_lo", 32'(dl >= 296), 1);
    chk("lat_hi", 32'(dl <= 320), 1);
    chk("a5_cnt", 32'(got[0].size() - n0), 1);

    for (int i = 0; i < 14; i++) begin
      k  = tv[i].k;
      n0 = got[k].size();
      send(k, tv[i].d, tv[i].hp, tv[i].p,
           tv[i].ns, tv[i].st);
      idle(64);
      chk($sformatf("v%0d_cnt", i),
          32'(got[k].size() - n0), 1);
      if (got[k].size() > n0)
        chk($sformatf("v%0d_ent", i),
            32'(got[k][n0]), 32'(tv[i].exp));
      chk($sformatf("v%0d_busy", i), 32'(busy), 0);
    end

    n0 = got[0].size();
    line[0] = 1'b0;
    idle(5);
    chk("gl_busy1", 32'(busy[0]), 1);
    idle(3);
    line[0] = 1'b1;
    idle(60);
    chk("gl_busy0", 32'(busy[0]), 0);
    chk("gl_valid", 32'(vld[0]), 0);
    chk("gl_cnt", 32'(got[0].size() - n0), 0);

    n0 = got[0].size();
    line[0] = 1'b0;
    idle(500);
    chk("brk_busy1", 32'(busy[0]), 1);
    idle(140);
    line[0] = 1'b1;
    idle(10);
    chk("brk_busy0", 32'(busy[0]), 0);
    idle(100);
    chk("brk_cnt", 32'(got[0].size() - n0), 1);
    if (got[0].size() > n0)
      chk("brk_ent", 32'(got[0][n0]), 32'h600);

    rdy[0] = 1'b0;
    n0 = got[0].size();
    o0 = ovr_n[0];
    for (int v = 1; v <= 4; v++)
      send(0, 8'(v), 1'b0, 1'b0, 1, 2'b01);
    idle(40);
    chk("ov_pre", 32'(ovr_n[0] - o0), 0);
    chk("ov_valid", 32'(vld[0]), 1);
    chk("ov_head", 32'(ent[0]), 32'h001);
    send(0, 8'h05, 1'b0, 1'b0, 1, 2'b01);
    idle(40);
    chk("ov_pulse", 32'(ovr_n[0] - o0), 1);
    chk("ov_head2", 32'(ent[0]), 32'h001);
    rdy[0] = 1'b1;
    idle(10);
    chk("dr_cnt", 32'(got[0].size() - n0), 4);
    for (int j = 0; j < 4; j++)
      if (got[0].size() > n0 + j)
        chk($sformatf("dr_%0d", j),
            32'(got[0][n0 + j]), 32'(j + 1));
    chk("dr_valid", 32'(vld[0]), 0);

    rdy[0] = 1'b0;
    send(0, 8'h11, 1'b0, 1'b0, 1, 2'b01);
    send(0, 8'h22, 1'b0, 1'b0, 1, 2'b01);
    idle(40);
    chk("mr_valid1", 32'(vld[0]), 1);
    line[0] = 1'b0;
    idle(100);
    chk("mr_busy1", 32'(busy[0]), 1);
    rst_n = 1'b0;
    idle(2);
    line[0] = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(2);
    chk("mr_valid0", 32'(vld[0]), 0);
    chk("mr_busy0", 32'(busy[0]), 0);
    chk("mr_head", 32'(ent[0]), 0);
    n0 = got[0].size();
    rdy[0] = 1'b1;
    idle(400);
    chk("mr_cnt", 32'(got[0].size() - n0), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Parametrised UART receiver replacing the fixed single-frame receiver: integrated baud/oversample tick generator, 3-sample majority voting, selectable parity and stop-bit count, per-frame parity/framing/break status, and a small output FIFO with valid/ready handshake plus an overrun pulse. Sits between the `uart_rx` pad (via no external synchroniser) and any consumer that may stall.

## Interface
- `CLK_FREQUENCE`, 50_000_000: clk frequency in Hz.
- `BAUD_RATE`, 115200: line rate in baud.
- `OVERSAMPLE`, 16: ticks per bit; even, 8..16.
- `FRAME_WD`, 8: data bits; 5..9.
- `PARITY`, "NONE": "NONE", "EVEN" or "ODD".
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: entries; power of two, >= 2.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `uart_rx` in 1: serial line, idle high, asynchronous.
- `rx_data` out FRAME_WD: head-of-FIFO data, LSB first on line.
- `rx_perr` out 1: head frame parity mismatch (0 when PARITY="NONE").
- `rx_ferr` out 1: head frame had a 0 in a stop bit.
- `rx_break` out 1: head frame is a break.
- `rx_valid` out 1: FIFO non-empty.
- `rx_ready` in 1: consumer accepts head when high with `rx_valid`.
- `rx_overrun` out 1: one-cycle pulse, frame dropped because FIFO full.
- `busy` out 1: FSM not in IDLE.

## Operation
- Synchroniser: 2 flops, reset to 1. Start detect = synced prev 1, synced now 0, FSM in IDLE.
- Tick generator: DIV = CLK_FREQUENCE/(BAUD_RATE*OVERSAMPLE), integer, >= 1. Counter 0..DIV-1, tick when DIV-1; cleared to 0 on start detect.
- Sample counter 0..OVERSAMPLE-1, advances on tick, wraps per bit, cleared on start detect. Samples taken at indices M-1, M, M+1 (M=OVERSAMPLE/2); bit value = majority, decided at index M+1 tick.
- States: IDLE -> START on start detect. START: majority 1 -> IDLE (false start, nothing pushed); 0 -> DATA at bit end. DATA: FRAME_WD bits shifted LSB-first, then PARITY (if enabled) else STOP. PARITY: perr = XOR(data, parity bit) for EVEN, inverse for ODD. STOP: STOP_BITS stop bits sampled; ferr if any is 0.
- At decision of the last stop bit (mid-bit, not bit end) the entry is pushed and FSM goes to IDLE, allowing back-to-back frames.
- Break: data all 0, parity bit (if any) 0, first stop bit 0 -> break=1, ferr=1, perr as computed; FSM goes BRK_WAIT until synced line is 1, then IDLE.
- FIFO entry = {break, ferr, perr, data}. Push when full: entry dropped, `rx_overrun` pulses, FIFO unchanged. Push and pop same cycle when full: both occur, no overrun. Pop on `rx_valid & rx_ready`.

## Timing
- Reset: `rx_data` 0, `rx_perr`/`rx_ferr`/`rx_break` 0, `rx_valid` 0, `rx_overrun` 0, `busy` 0; FIFO emptied, FSM IDLE. Reset mid-frame aborts frame, no push.
- Start detect 3 clk after pad falling edge (2 sync + edge reg). `busy` high the cycle after start detect.
- `rx_valid` and head fields registered: valid 1 clk after push into empty FIFO; show-ahead (fields stable while `rx_valid` and not popped).
- Head updates 1 clk after pop; `rx_valid` falls 1 clk after popping the last entry.
- `rx_overrun` is high exactly the cycle after the dropped push.

## Structure
- Package `uart_pkg`: parity-mode localparams, entry field offsets (DATA, PERR, FERR, BRK), DIV calculation function, FSM state encoding.
- Sub-module `uart_rx_fifo`: synchronous show-ahead FIFO, WIDTH/DEPTH params, push/pop/full/empty; instanced once.
- Tick generator, synchroniser and FSM stay in `uart_rx_core`.

## Test plan
Config CLK_FREQUENCE=3_200_000, BAUD_RATE=100_000, OVERSAMPLE=16 (DIV=2, 32 clk/bit), rx_ready=1 unless stated.
- 8N1 frame 0xA5 -> one entry, rx_data=0xA5, perr=ferr=break=0; rx_valid ~ 9.5 bit times + 4 clk after start edge.
- PARITY="EVEN", byte 0x07 sent with parity bit 0 -> rx_perr=1; parity bit 1 -> rx_perr=0; ODD inverse.
- Low glitch of 8 clk on idle line -> START rejects, no push, busy returns 0, rx_valid stays 0.
- STOP_BITS=2, second stop bit 0 on 0x3C -> rx_data=0x3C, rx_ferr=1, break=0.
- Line held low 20 bit times -> one entry rx_data=0, break=1, ferr=1; busy held until line high; no further entries.
- rx_ready=0, FIFO_DEPTH=4, send 5 frames 0x01..0x05 -> entries 0x01..0x04 retained, rx_overrun single pulse on frame 5; then drain yields 0x01..0x04 in order; reset mid-frame empties FIFO.
